// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 16-bit shifter (SLL / SRA / ROR).
// At most one grant per cycle; the result lands in a single-entry response
// buffer together with the source ID and the requester's tag.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req0_* / req1_*               valid/ready handshake plus data, amt, mode, tag
//   rsp_valid / rsp_ready         response buffer handshake
//   rsp_data, rsp_src, rsp_tag    shifted result, granted source, returned tag
//   rsp_illegal                   granted request used mode 3 (operand passed through)
//
// Parameters
//   TAG_W         tag width
//   ARB_MODE      0 = round-robin, 1 = fixed priority to req0 with starvation guard
//   STARVE_LIMIT  ARB_MODE=1: cycles req1 may be passed over before a forced grant
module shift_arbiter #(
  parameter int TAG_W        = 4,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_data,
  input  logic [3:0]       req0_amt,
  input  logic [1:0]       req0_mode,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_data,
  input  logic [3:0]       req1_amt,
  input  logic [1:0]       req1_mode,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal
);

  localparam int CNT_W = 8;

  logic             slot_free;
  logic             last_grant;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             gnt0;
  logic             gnt1;

  logic [15:0]      sel_data;
  logic [3:0]       sel_amt;
  logic [1:0]       sel_mode;
  logic [TAG_W-1:0] sel_tag;
  logic [15:0]      shift_res;
  logic             shift_illegal;
  logic signed [15:0] sra_in;
  logic [31:0]      ror_dbl;

  assign slot_free = !rsp_valid || rsp_ready;
  assign starved   = (ARB_MODE != 0) && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && slot_free) begin
      if (req0_valid && req1_valid) begin
        if (ARB_MODE == 0) begin
          // last_grant resets to 1 so req0 takes the first conflict
          if (last_grant) gnt0 = 1'b1;
          else            gnt1 = 1'b1;
        end else begin
          if (starved) gnt1 = 1'b1;
          else         gnt0 = 1'b1;
        end
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sel_data = gnt1 ? req1_data : req0_data;
  assign sel_amt  = gnt1 ? req1_amt  : req0_amt;
  assign sel_mode = gnt1 ? req1_mode : req0_mode;
  assign sel_tag  = gnt1 ? req1_tag  : req0_tag;

  always_comb begin
    sra_in        = sel_data;
    // rotate right = low half of the doubled operand shifted right
    ror_dbl       = {sel_data, sel_data} >> sel_amt;
    shift_res     = sel_data;
    shift_illegal = 1'b0;
    case (sel_mode)
      2'd0:    shift_res = sel_data << sel_amt;
      2'd1:    shift_res = sra_in >>> sel_amt;
      2'd2:    shift_res = ror_dbl[15:0];
      default: shift_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_src     <= 1'b0;
      rsp_tag     <= '0;
      rsp_illegal <= 1'b0;
    end else if (gnt0 || gnt1) begin
      rsp_valid   <= 1'b1;
      rsp_data    <= shift_res;
      rsp_src     <= gnt1;
      rsp_tag     <= sel_tag;
      rsp_illegal <= shift_illegal;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ARB_MODE == 0) begin
      starve_cnt <= '0;
    end else if (!req1_valid || gnt1) begin
      starve_cnt <= '0;
    end else if (slot_free && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic [1:0]  req0_mode, req1_mode;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp_ready;

  // round-robin instance
  logic        r_ready0, r_ready1, r_valid, r_src, r_ill;
  logic [15:0] r_data;
  logic [3:0]  r_tag;
  // fixed-priority instance, same stimulus
  logic        f_ready0, f_ready1, f_valid, f_src, f_ill;
  logic [15:0] f_data;
  logic [3:0]  f_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.TAG_W(4), .ARB_MODE(0), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r_ready0), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_mode(req0_mode), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(r_ready1), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_mode(req1_mode), .req1_tag(req1_tag),
    .rsp_valid(r_valid), .rsp_ready(rsp_ready), .rsp_data(r_data),
    .rsp_src(r_src), .rsp_tag(r_tag), .rsp_illegal(r_ill)
  );

  shift_arbiter #(.TAG_W(4), .ARB_MODE(1), .STARVE_LIMIT(4)) dut_fix (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_ready0), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_mode(req0_mode), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(f_ready1), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_mode(req1_mode), .req1_tag(req1_tag),
    .rsp_valid(f_valid), .rsp_ready(rsp_ready), .rsp_data(f_data),
    .rsp_src(f_src), .rsp_tag(f_tag), .rsp_illegal(f_ill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [15:0] d, input logic [3:0] a,
                      input logic [1:0] m, input logic [3:0] t);
    req0_valid = v; req0_data = d; req0_amt = a; req0_mode = m; req0_tag = t;
  endtask

  task automatic set1(input logic v, input logic [15:0] d, input logic [3:0] a,
                      input logic [1:0] m, input logic [3:0] t);
    req1_valid = v; req1_data = d; req1_amt = a; req1_mode = m; req1_tag = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  logic [1:0]  sw_mode [5] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd3};
  logic [3:0]  sw_amt  [5] = '{4'd4, 4'd15, 4'd15, 4'd0, 4'd5};
  logic [15:0] sw_exp  [5] = '{16'h0A5F, 16'h0000, 16'hFFFF, 16'hA5F0, 16'hA5F0};
  logic        sw_ill  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    set0(1'b1, 16'h0, 4'd0, 2'd0, 4'd0);
    set1(1'b0, 16'h0, 4'd0, 2'd0, 4'd0);
    cyc();
    #1;
    chk("ready0_in_reset", {31'd0, r_ready0}, 32'd0);
    cyc();
    rst = 1'b0;
    req0_valid = 1'b0;
    chk("reset_rsp_valid", {31'd0, r_valid}, 32'd0);
    chk("reset_rsp_data", {16'd0, r_data}, 32'd0);

    // 1: single request from req0, SRA
    set0(1'b1, 16'h8001, 4'd1, 2'd1, 4'd3);
    #1;
    chk("t1_ready0", {31'd0, r_ready0}, 32'd1);
    chk("t1_ready1", {31'd0, r_ready1}, 32'd0);
    cyc();
    req0_valid = 1'b0;
    chk("t1_rsp_valid", {31'd0, r_valid}, 32'd1);
    chk("t1_rsp_data", {16'd0, r_data}, 32'h0000C000);
    chk("t1_rsp_src", {31'd0, r_src}, 32'd0);
    chk("t1_rsp_tag", {28'd0, r_tag}, 32'd3);
    chk("t1_rsp_ill", {31'd0, r_ill}, 32'd0);
    cyc();
    chk("t1_accept_valid", {31'd0, r_valid}, 32'd0);
    chk("t1_accept_hold", {16'd0, r_data}, 32'h0000C000);

    // 2: round-robin alternation, starts with req0 after reset
    do_reset();
    set0(1'b1, 16'h0001, 4'd4, 2'd0, 4'd1);
    set1(1'b1, 16'h8000, 4'd1, 2'd2, 4'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_ready0", {31'd0, r_ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_ready1", {31'd0, r_ready1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      cyc();
      chk("t2_rsp_valid", {31'd0, r_valid}, 32'd1);
      chk("t2_rsp_src", {31'd0, r_src}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("t2_rsp_tag", {28'd0, r_tag}, (i % 2 == 1) ? 32'd2 : 32'd1);
      chk("t2_rsp_data", {16'd0, r_data}, (i % 2 == 1) ? 32'h4000 : 32'h0010);
    end

    // 3: back-pressure holds the buffer and blocks grants
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_ready0", {31'd0, r_ready0}, 32'd0);
      chk("t3_ready1", {31'd0, r_ready1}, 32'd0);
      cyc();
      chk("t3_hold_valid", {31'd0, r_valid}, 32'd1);
      chk("t3_hold_data", {16'd0, r_data}, 32'h4000);
      chk("t3_hold_tag", {28'd0, r_tag}, 32'd2);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_release_ready0", {31'd0, r_ready0}, 32'd1);
    chk("t3_release_ready1", {31'd0, r_ready1}, 32'd0);
    cyc();
    chk("t3_release_valid", {31'd0, r_valid}, 32'd1);
    chk("t3_release_tag", {28'd0, r_tag}, 32'd1);
    chk("t3_release_data", {16'd0, r_data}, 32'h0010);

    // 4: fixed priority with starvation guard (limit 4)
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_ready0", {31'd0, f_ready0}, (i % 5 == 4) ? 32'd0 : 32'd1);
      chk("t4_ready1", {31'd0, f_ready1}, (i % 5 == 4) ? 32'd1 : 32'd0);
      cyc();
      chk("t4_rsp_src", {31'd0, f_src}, (i % 5 == 4) ? 32'd1 : 32'd0);
      chk("t4_rsp_valid", {31'd0, f_valid}, 32'd1);
    end

    // 5: mode / amount sweep on req0 alone
    req1_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set0(1'b1, 16'hA5F0, sw_amt[i], sw_mode[i], 4'(i));
      cyc();
      chk("t5_data", {16'd0, r_data}, {16'd0, sw_exp[i]});
      chk("t5_illegal", {31'd0, r_ill}, {31'd0, sw_ill[i]});
      chk("t5_tag", {28'd0, r_tag}, i);
    end

    // 6: reset while a response is pending and both requesters valid
    set0(1'b1, 16'h1234, 4'd1, 2'd0, 4'd5);
    set1(1'b1, 16'h5678, 4'd1, 2'd0, 4'd6);
    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_ready0_rst", {31'd0, r_ready0}, 32'd0);
    chk("t6_ready1_rst", {31'd0, r_ready1}, 32'd0);
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;
    chk("t6_rsp_valid", {31'd0, r_valid}, 32'd0);
    chk("t6_rsp_data", {16'd0, r_data}, 32'd0);
    chk("t6_rsp_src", {31'd0, r_src}, 32'd0);
    chk("t6_rsp_tag", {28'd0, r_tag}, 32'd0);
    chk("t6_rsp_ill", {31'd0, r_ill}, 32'd0);
    #1;
    chk("t6_first_ready0", {31'd0, r_ready0}, 32'd1);
    chk("t6_first_ready1", {31'd0, r_ready1}, 32'd0);
    cyc();
    chk("t6_first_tag", {28'd0, r_tag}, 32'd5);
    chk("t6_first_data", {16'd0, r_data}, 32'h2468);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
